alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 167 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes into a main register backed by one skid register.
// Optional macro ALU_ISSUE_UPPER_IMM_EN adds LUI/AUIPC decode.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  aluop_control,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    typedef struct packed {
        logic [3:0]  aluop;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t state_reg;
    entry_t main_reg;
    entry_t skid_reg;
    entry_t dec_next;
    logic   out_valid_reg;
    logic   in_ready_reg;
    logic   legal;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // rs1 field is never needed: register values arrive already read
    logic unused_rs1_field;
    assign unused_rs1_field = ^in_instr[19:15];

`ifndef ALU_ISSUE_UPPER_IMM_EN
    logic unused_pc;
    assign unused_pc = ^in_pc;
`endif

    always_comb begin
        dec_next = '0;
        legal    = 1'b0;
        case (opcode)
            7'b0110011: begin
                legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                dec_next.aluop = {funct7[5], funct3};
                dec_next.op1   = in_rs1_data;
                dec_next.op2   = in_rs2_data;
            end
            7'b0010011: begin
                legal          = 1'b1;
                dec_next.aluop = {1'b0, funct3};
                dec_next.op1   = in_rs1_data;
                dec_next.op2   = {{20{in_instr[31]}}, in_instr[31:20]};
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    // shift amount is zero-extended; bit 30 picks arithmetic shift
                    legal          = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    dec_next.aluop = {in_instr[30], 3'b101};
                    dec_next.op2   = {27'b0, in_instr[24:20]};
                end
            end
`ifdef ALU_ISSUE_UPPER_IMM_EN
            7'b0110111: begin
                legal          = 1'b1;
                dec_next.aluop = 4'b0000;
                dec_next.op1   = 32'b0;
                dec_next.op2   = {in_instr[31:12], 12'b0};
            end
            7'b0010111: begin
                legal          = 1'b1;
                dec_next.aluop = 4'b0000;
                dec_next.op1   = in_pc;
                dec_next.op2   = {in_instr[31:12], 12'b0};
            end
`endif
            default: legal = 1'b0;
        endcase
        dec_next.rd = in_instr[11:7];
        if (!legal) begin
            dec_next         = '0;
            dec_next.illegal = 1'b1;
        end
    end

    logic in_xfer;
    logic out_xfer;
    assign in_xfer  = in_valid && in_ready_reg;
    assign out_xfer = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else if (flush) begin
            // a same-cycle output transfer is simply consumed; everything else is dropped
            state_reg     <= ST_EMPTY;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_reg      <= dec_next;
                        state_reg     <= ST_ONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_reg <= dec_next;
                    end else if (in_xfer) begin
                        skid_reg      <= dec_next;
                        state_reg     <= ST_TWO;
                        in_ready_reg  <= 1'b0;
                    end else if (out_xfer) begin
                        state_reg     <= ST_EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        main_reg     <= skid_reg;
                        state_reg    <= ST_ONE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_EMPTY;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_reg;
    assign out_valid     = out_valid_reg;
    assign aluop_control = main_reg.aluop;
    assign operand1      = main_reg.op1;
    assign operand2      = main_reg.op2;
    assign out_rd        = main_reg.rd;
    assign out_illegal   = main_reg.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios then random traffic against a queue model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  aluop_control;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluop_control(aluop_control), .operand1(operand1), .operand2(operand2),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [3:0]  aluop;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode phrased by instruction class and mnemonic
    function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit ok;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [11:0] imm;
        f7 = instr[31:25];
        f3 = instr[14:12];
        imm = instr[31:20];
        ok = 0;
        e.aluop = 0; e.op1 = 0; e.op2 = 0; e.rd = instr[11:7]; e.illegal = 0;
        if (instr[6:0] == 7'h33) begin
            if (f7 == 7'h00) begin ok = 1; e.aluop = {1'b0, f3}; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; e.aluop = 4'd8; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.aluop = 4'd13; end
            e.op1 = a; e.op2 = b;
        end else if (instr[6:0] == 7'h13) begin
            e.op1 = a;
            if (f3 == 3'd1) begin
                ok = (f7 == 0); e.aluop = 4'd1; e.op2 = 32'(instr[24:20]);
            end else if (f3 == 3'd5) begin
                ok = (f7 == 0 || f7 == 7'h20);
                e.aluop = (f7 == 7'h20) ? 4'd13 : 4'd5;
                e.op2 = 32'(instr[24:20]);
            end else begin
                ok = 1; e.aluop = {1'b0, f3}; e.op2 = 32'($signed(imm));
            end
        end
`ifdef ALU_ISSUE_UPPER_IMM_EN
        else if (instr[6:0] == 7'h37) begin
            ok = 1; e.op2 = instr & 32'hFFFFF000;
        end else if (instr[6:0] == 7'h17) begin
            ok = 1; e.op1 = pc; e.op2 = instr & 32'hFFFFF000;
        end
`endif
        if (!ok) begin
            e.aluop = 0; e.op1 = 0; e.op2 = 0; e.rd = 0; e.illegal = 1;
        end
        return e;
    endfunction

    // One clock: check outputs against the model, then advance the model on the edge
    task automatic cycle();
        bit acc;
        bit pop;
        exp_t e;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("aluop", 32'(aluop_control), 32'(q[0].aluop));
            chk("operand1", operand1, q[0].op1);
            chk("operand2", operand2, q[0].op2);
            chk("rd", 32'(out_rd), 32'(q[0].rd));
            chk("illegal", 32'(out_illegal), 32'(q[0].illegal));
            if (out_ready)
                $display("OUT op=%h op1=%h op2=%h rd=%0d ill=%0d", aluop_control, operand1,
                         operand2, out_rd, out_illegal);
        end
        acc = in_valid && (q.size() < 2);
        pop = (q.size() > 0) && out_ready;
        e = ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = v; in_instr = instr; in_rs1_data = a; in_rs2_data = b;
        in_pc = $urandom;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] f7s [4];
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'h7F;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w = {f7s[$urandom_range(0, 3)], w[24:7], 7'h33};
            1: w = {w[31:7], 7'h13};
            2: w = {f7s[$urandom_range(0, 3)], w[24:15], 3'd5, w[11:7], 7'h13};
            3: w = {f7s[$urandom_range(0, 3)], w[24:15], 3'd1, w[11:7], 7'h13};
            4: w = {w[31:7], ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_aluop", 32'(aluop_control), 0);
        chk("rst_operand1", operand1, 0);
        chk("rst_operand2", operand2, 0);
        chk("rst_rd", 32'(out_rd), 0);
        chk("rst_illegal", 32'(out_illegal), 0);
        @(posedge clk); #1;

        // ADD x3, x1, x2
        out_ready = 1;
        drive(1, 32'h002081B3, 5, 7); cycle();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_op2", operand2, 7);
        chk("add_rd", 32'(out_rd), 3);
        @(posedge clk); #1;
        q.delete();

        // SRAI x5, x6, 3
        drive(1, 32'h40335293, 32'h80000000, 32'hDEADBEEF); cycle();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("srai_aluop", 32'(aluop_control), 4'b1101);
        chk("srai_op2", operand2, 3);
        chk("srai_rd", 32'(out_rd), 5);
        @(posedge clk); #1;
        q.delete();

        // A, B, C back-to-back against a stalled consumer
        out_ready = 0;
        drive(1, 32'h00208033, 1, 2); cycle();
        drive(1, 32'h40208033, 3, 4); cycle();
        drive(1, 32'h0020E033, 5, 6); cycle(); cycle();
        out_ready = 1;
        cycle();
        drive(0, 0, 0, 0);
        repeat (4) cycle();

        // all-zero word is illegal
        drive(1, 32'h00000000, 9, 9); cycle();
        drive(0, 0, 0, 0); cycle();

        // flush in TWO with a competing input
        out_ready = 0;
        drive(1, 32'h00100093, 1, 1); cycle();
        drive(1, 32'h00200113, 2, 2); cycle();
        flush = 1; drive(1, 32'h00300193, 3, 3); cycle();
        flush = 0; drive(0, 0, 0, 0);
        out_ready = 1;
        repeat (3) cycle();

        // LUI x1, 0x12345
        drive(1, 32'h123450B7, 0, 0); cycle();
        drive(0, 0, 0, 0);
        @(negedge clk);
`ifdef ALU_ISSUE_UPPER_IMM_EN
        chk("lui_op2", operand2, 32'h12345000);
        chk("lui_illegal", 32'(out_illegal), 0);
`else
        chk("lui_illegal", 32'(out_illegal), 1);
`endif
        @(posedge clk); #1;
        q.delete();

        // reset mid-operation with a pending input
        out_ready = 0;
        drive(1, 32'h00500293, 1, 1); cycle();
        drive(1, 32'h00600313, 1, 1); cycle();
        rst = 1; cycle();
        rst = 0; drive(0, 0, 0, 0); out_ready = 1;
        repeat (2) cycle();

        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom);
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 24) == 0;
            rst = $urandom_range(0, 99) == 0;
            cycle();
        end
        rst = 0; flush = 0; drive(0, 0, 0, 0); out_ready = 1;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
